// File: rtl/barrier_map_writer_if.sv
// Bus bundle between the obstacle configuration logic and the barrier map writer.
// It carries the slot-programming port, the scan request and the barrier BRAM write port.
interface barrier_map_writer_if #(
   parameter int ADDR_W  = 16,
   parameter int COORD_W = 8,
   parameter int IDX_W   = 2
);
   logic               rect_we_in;
   logic [IDX_W-1:0]   rect_idx_in;
   logic               rect_en_in;
   logic [COORD_W-1:0] rect_x0_in;
   logic [COORD_W-1:0] rect_x1_in;
   logic [COORD_W-1:0] rect_y0_in;
   logic [COORD_W-1:0] rect_y1_in;
   logic [1:0]         mode_in;
   logic               start_in;
   logic [ADDR_W-1:0]  bram_addr_out;
   logic               bram_data_out;
   logic               bram_we_out;
   logic               busy_out;
   logic               done_out;

   // The configuration side drives the slot port and the scan request, and it watches the write port.
   modport master (
      output rect_we_in, rect_idx_in, rect_en_in,
      output rect_x0_in, rect_x1_in, rect_y0_in, rect_y1_in,
      output mode_in, start_in,
      input  bram_addr_out, bram_data_out, bram_we_out, busy_out, done_out
   );

   // The writer side is the mirror image of the master modport.
   modport slave (
      input  rect_we_in, rect_idx_in, rect_en_in,
      input  rect_x0_in, rect_x1_in, rect_y0_in, rect_y1_in,
      input  mode_in, start_in,
      output bram_addr_out, bram_data_out, bram_we_out, busy_out, done_out
   );
endinterface

// File: rtl/barrier_map_writer.sv
// Barrier map writer: scans the whole grid once for each start request.
// It writes one barrier bit per cell. A bit is set when the cell falls inside the union of the enabled rectangles,
// or on an optional channel wall. The final bit can optionally be inverted.
module barrier_map_writer #(
   parameter int GRID_W    = 256,
   parameter int GRID_H    = 256,
   parameter int ADDR_W    = 16,
   parameter int COORD_W   = 8,
   parameter int NUM_RECTS = 4
) (
   input logic                clk_in,
   input logic                rst_in,
   barrier_map_writer_if.slave bus
);
   localparam int IDX_W = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1;
   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(GRID_W - 1);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(GRID_H - 1);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   state_t state, state_nxt;

   logic               slot_en_q [NUM_RECTS];
   logic [COORD_W-1:0] slot_x0_q [NUM_RECTS];
   logic [COORD_W-1:0] slot_x1_q [NUM_RECTS];
   logic [COORD_W-1:0] slot_y0_q [NUM_RECTS];
   logic [COORD_W-1:0] slot_y1_q [NUM_RECTS];

   logic [COORD_W-1:0] x_q, y_q;
   logic [ADDR_W-1:0]  cell_addr_q;
   logic               wall_q, invert_q;

   logic               accept_start, last_cell, any_hit, wall_hit, cell_bit;
   logic               we_d, data_d, busy_d, done_d;
   logic [ADDR_W-1:0]  addr_d;

   assign accept_start = (state == S_IDLE) && bus.start_in;
   assign last_cell    = (x_q == X_LAST) && (y_q == Y_LAST);
   assign wall_hit     = wall_q && ((y_q == '0) || (y_q == Y_LAST));
   assign cell_bit     = (any_hit | wall_hit) ^ invert_q;

   // The slot table only accepts writes in IDLE, so a scan always sees one consistent obstacle set.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int k = 0; k < NUM_RECTS; k++) begin
            slot_en_q[k] <= 1'b0;
            slot_x0_q[k] <= '0;
            slot_x1_q[k] <= '0;
            slot_y0_q[k] <= '0;
            slot_y1_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_RECTS; k++) begin
            if ((state == S_IDLE) && bus.rect_we_in && (bus.rect_idx_in == IDX_W'(k))) begin
               slot_en_q[k] <= bus.rect_en_in;
               slot_x0_q[k] <= bus.rect_x0_in;
               slot_x1_q[k] <= bus.rect_x1_in;
               slot_y0_q[k] <= bus.rect_y0_in;
               slot_y1_q[k] <= bus.rect_y1_in;
            end
         end
      end
   end

   // A cell is a hit when any enabled slot contains it. An inverted range naturally matches nothing.
   always_comb begin
      any_hit = 1'b0;
      for (int k = 0; k < NUM_RECTS; k++) begin
         if (slot_en_q[k] &&
             (x_q >= slot_x0_q[k]) && (x_q <= slot_x1_q[k]) &&
             (y_q >= slot_y0_q[k]) && (y_q <= slot_y1_q[k])) begin
            any_hit = 1'b1;
         end
      end
   end

   // State register for the scan sequencer.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: IDLE waits for start, SCAN runs until the last cell, and DONE lasts exactly one cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.start_in) state_nxt = S_SCAN;
         S_SCAN:  if (last_cell) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output values for the next edge. A SCAN cycle emits the current cell, and a DONE cycle emits the completion pulse.
   always_comb begin
      we_d   = 1'b0;
      data_d = 1'b0;
      busy_d = 1'b0;
      done_d = 1'b0;
      addr_d = bus.bram_addr_out;
      case (state)
         S_SCAN: begin
            we_d   = 1'b1;
            busy_d = 1'b1;
            data_d = cell_bit;
            addr_d = cell_addr_q;
         end
         S_DONE:  done_d = 1'b1;
         default: ;
      endcase
   end

   // The cell walker runs the address counter alongside x/y, so the design needs no y*GRID_W multiplier.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         x_q         <= '0;
         y_q         <= '0;
         cell_addr_q <= '0;
         wall_q      <= 1'b0;
         invert_q    <= 1'b0;
      end else if (accept_start) begin
         x_q         <= '0;
         y_q         <= '0;
         cell_addr_q <= '0;
         wall_q      <= bus.mode_in[0];
         invert_q    <= bus.mode_in[1];
      end else if (state == S_SCAN) begin
         cell_addr_q <= cell_addr_q + 1'b1;
         if (x_q == X_LAST) begin
            x_q <= '0;
            y_q <= y_q + 1'b1;
         end else begin
            x_q <= x_q + 1'b1;
         end
      end
   end

   // The write port is fully registered so the BRAM sees clean, glitch-free strobes.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         bus.bram_we_out   <= 1'b0;
         bus.bram_data_out <= 1'b0;
         bus.bram_addr_out <= '0;
         bus.busy_out      <= 1'b0;
         bus.done_out      <= 1'b0;
      end else begin
         bus.bram_we_out   <= we_d;
         bus.bram_data_out <= data_d;
         bus.bram_addr_out <= addr_d;
         bus.busy_out      <= busy_d;
         bus.done_out      <= done_d;
      end
   end
endmodule

// File: doc/barrier_map_writer.md
Name: barrier_map_writer

Overview:
- Sequential generator that fills the simulation's barrier BRAM (1 bit per cell, 1 = solid barrier, 0 = fluid) by scanning the whole grid once per start request.
- Barrier shape = union of up to NUM_RECTS runtime-programmable rectangles, plus optional channel walls and optional inversion.
- Sits between the control/config logic and the barrier BRAM write port; runs at init and whenever the user reconfigures obstacles.

Parameters:
- GRID_W, 256, grid width in cells (x range 0..GRID_W-1)
- GRID_H, 256, grid height in cells (y range 0..GRID_H-1)
- ADDR_W, 16, BRAM address width; GRID_W*GRID_H must be <= 2^ADDR_W
- COORD_W, 8, width of x/y coordinates
- NUM_RECTS, 4, number of rectangle slots (>= 1)

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous active-high reset
- rect_we_in  input  1  write one rectangle slot this cycle
- rect_idx_in  input  $clog2(NUM_RECTS) (min 1)  slot index
- rect_en_in  input  1  slot enable value
- rect_x0_in, rect_x1_in  input  COORD_W each  inclusive x bounds
- rect_y0_in, rect_y1_in  input  COORD_W each  inclusive y bounds
- mode_in  input  2  bit0 = add walls on rows 0 and GRID_H-1; bit1 = invert final bit
- start_in  input  1  request a full-grid scan
- bram_addr_out  output  ADDR_W  write address = y*GRID_W + x
- bram_data_out  output  1  barrier bit for bram_addr_out
- bram_we_out  output  1  write strobe
- busy_out  output  1  high while scanning
- done_out  output  1  one-cycle pulse after last write

Behaviour:
- Reset (async assert, registers cleared immediately): all slots disabled with coords 0; state IDLE; x=y=0; bram_addr_out=0, bram_data_out=0, bram_we_out=0, busy_out=0, done_out=0.
- Slot write: rect_we_in with rect_idx_in < NUM_RECTS updates that slot at the clock edge; idx >= NUM_RECTS ignored. Writes while busy_out=1 are ignored (table frozen during scan).
- Cell hit for slot k: en && x0<=x<=x1 && y0<=y<=y1 (unsigned). x0>x1 or y0>y1 matches nothing. Bounds beyond grid clip naturally.
- bit = OR of all slot hits, OR (wall && (y==0 || y==GRID_H-1)); then XOR invert. mode_in latched on accepted start; changes mid-scan have no effect.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: start_in=1 -> latch mode, x=y=0, go SCAN. start_in ignored in SCAN and DONE.
  - SCAN: each cycle outputs are registered from current (x,y): bram_we_out=1, addr, data; then x++; at x==GRID_W-1, x=0 and y++; after cell (GRID_W-1,GRID_H-1) go DONE.
  - DONE: one cycle, done_out=1, bram_we_out=0, busy_out=0 -> IDLE.
- Timing: start sampled at edge N -> first write (addr 0) visible after edge N+1; last write visible after edge N+GRID_W*GRID_H; done_out high after the following edge. Exactly GRID_W*GRID_H writes, addresses strictly ascending, no gaps or repeats.
- busy_out=1 from first write cycle through last write cycle inclusive.
- bram_addr_out computed with multiply-free incremental counter (addr++ per cell); must equal y*GRID_W+x.
- Reset mid-scan: writes stop immediately, no done pulse, slot table cleared.
- Simultaneous rect_we_in and start_in in IDLE: slot write takes effect and scan uses the updated table.

Test Plan:
- GRID_W=8, GRID_H=4, reset, no slots, mode 0, start -> 32 writes addr 0..31 all data 0, done_out pulse once, busy_out high exactly 32 cycles.
- Slot0 = en, x 2..3, y 1..2, start -> data=1 only at addrs 10,11,18,19; all other 0.
- Slot0 x 1..2 y 0..0 plus slot1 x 2..5 y 0..0, mode 1 -> rows 0 and 3 all 1 (addrs 0..7, 24..31), rows 1-2 all 0; mode 3 -> exact complement.
- Slot with x0=5, x1=2 enabled -> all 0; rect_idx_in=3 with NUM_RECTS=3 -> ignored; slot write during scan -> current and next scan unaffected until written in IDLE.
- Assert rst_in at write 12 -> outputs 0 immediately, no done_out; subsequent start scans with empty table -> all 0.
- start_in held high continuously -> back-to-back scans separated by exactly one DONE cycle and one IDLE cycle, no extra starts while busy.
